// File: rtl/exp8_pkg.sv
// Shared types for the one-hot sequence checker: FSM states, sample classes, lock default.
// Combinational definitions only; no latency, no flow control.
package exp8_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } seq_state_t;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    ONEHOT = 2'd1,
    MULTI  = 2'd2
  } sample_cls_t;

  localparam int LOCK_STEPS_DEF = 4;

endpackage

// File: rtl/onehot_encoder4.sv
// Classifies a 4-line bus as zero / one-hot / multi and encodes it to a 2-bit code.
// Purely combinational (0 cycles); no backpressure.
module onehot_encoder4
  import exp8_pkg::*;
(
  input  logic [3:0] decoder_in,
  output logic [1:0] sample_cls,
  output logic [1:0] code
);

  always_comb begin
    code = 2'd0;
    // Scan downwards so the lowest set bit is the one that sticks.
    for (int i = 3; i >= 0; i--) begin
      if (decoder_in[i]) code = 2'(i);
    end
  end

  always_comb begin
    sample_cls = ZERO;
    if (decoder_in != 4'b0000) begin
      sample_cls = ((decoder_in & (decoder_in - 4'd1)) != 4'b0000) ? MULTI : ONEHOT;
    end
  end

endmodule

// File: rtl/onehot_seq_encoder.sv
// Encodes a one-hot bus each edge, checks the 0-1-2-3 up-count order and locks after a run of in-order steps.
// All outputs registered, 1-cycle latency; no backpressure (samples every edge).
module onehot_seq_encoder
  import exp8_pkg::*;
#(
  parameter int LOCK_STEPS = LOCK_STEPS_DEF,
  parameter int CNT_W      = 8
) (
  input  logic             clockpulse,
  input  logic             clear_,
  input  logic [3:0]       decoder_in,
  output logic [1:0]       encoder_out,
  output logic             valid,
  output logic             invalid_code,
  output logic             seq_err,
  output logic             locked,
  output logic [CNT_W-1:0] step_count
);

  localparam logic [3:0] LOCK_RUN = LOCK_STEPS[3:0];

  logic [1:0]       sample_cls;
  logic [1:0]       code;
  seq_state_t       state, state_n;
  logic [1:0]       prev, prev_n;
  logic [3:0]       run, run_n;
  logic [CNT_W-1:0] cnt_n;
  logic             valid_n, inv_n, err_n;
  logic             is_onehot, is_multi, in_order, is_repeat;

  onehot_encoder4 u_enc (
    .decoder_in (decoder_in),
    .sample_cls (sample_cls),
    .code       (code)
  );

  assign is_onehot = (sample_cls == ONEHOT);
  assign is_multi  = (sample_cls == MULTI);
  assign in_order  = is_onehot && (code == 2'(prev + 2'd1));
  assign is_repeat = is_onehot && (code == prev);

  always_comb begin
    state_n = state;
    prev_n  = prev;
    run_n   = run;
    cnt_n   = step_count;
    valid_n = is_onehot;
    inv_n   = 1'b0;
    err_n   = 1'b0;

    if (is_onehot) prev_n = code;

    unique case (state)
      SEARCH: begin
        if (is_onehot) begin
          run_n   = 4'd0;
          state_n = TRACK;
        end else if (is_multi) begin
          inv_n = 1'b1;
        end
      end
      TRACK, LOCKED: begin
        if (in_order) begin
          if (step_count != {CNT_W{1'b1}}) cnt_n = step_count + CNT_W'(1);
          // run only matters until lock is reached; it is frozen while LOCKED.
          if (state == TRACK) begin
            run_n = run + 4'd1;
            if (run_n == LOCK_RUN) state_n = LOCKED;
          end
        end else if (is_multi) begin
          inv_n   = 1'b1;
          run_n   = 4'd0;
          state_n = SEARCH;
        end else if (is_onehot && !is_repeat) begin
          err_n   = 1'b1;
          run_n   = 4'd0;
          state_n = TRACK;
        end
      end
      default: begin
        run_n   = 4'd0;
        state_n = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clockpulse or negedge clear_) begin
    if (!clear_) begin
      state        <= SEARCH;
      prev         <= 2'd0;
      run          <= 4'd0;
      step_count   <= '0;
      valid        <= 1'b0;
      invalid_code <= 1'b0;
      seq_err      <= 1'b0;
    end else begin
      state        <= state_n;
      prev         <= prev_n;
      run          <= run_n;
      step_count   <= cnt_n;
      valid        <= valid_n;
      invalid_code <= inv_n;
      seq_err      <= err_n;
    end
  end

  assign encoder_out = prev;
  assign locked      = (state == LOCKED);

endmodule

// File: tb/tb_onehot_seq_encoder.sv
// Directed bench for onehot_seq_encoder: two instances (8-bit and 2-bit step counters) share stimulus.
module tb_onehot_seq_encoder;

  logic       clockpulse = 1'b0;
  logic       clear_     = 1'b0;
  logic [3:0] decoder_in = 4'b0000;

  logic [1:0] eo_a, eo_b;
  logic       vld_a, vld_b, inv_a, inv_b, err_a, err_b, lk_a, lk_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  onehot_seq_encoder #(.LOCK_STEPS(4), .CNT_W(8)) dut (
    .clockpulse(clockpulse), .clear_(clear_), .decoder_in(decoder_in),
    .encoder_out(eo_a), .valid(vld_a), .invalid_code(inv_a), .seq_err(err_a),
    .locked(lk_a), .step_count(cnt_a)
  );

  onehot_seq_encoder #(.LOCK_STEPS(4), .CNT_W(2)) dut_sat (
    .clockpulse(clockpulse), .clear_(clear_), .decoder_in(decoder_in),
    .encoder_out(eo_b), .valid(vld_b), .invalid_code(inv_b), .seq_err(err_b),
    .locked(lk_b), .step_count(cnt_b)
  );

  always #5 clockpulse = ~clockpulse;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Behavioural model, one slot per instance.
  int m_cnt_max[2] = '{255, 3};
  bit m_have_ref[2], m_locked[2], m_vld[2], m_inv[2], m_err[2];
  int m_prev[2], m_run[2], m_cnt[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_have_ref[i] = 0; m_locked[i] = 0; m_vld[i] = 0; m_inv[i] = 0; m_err[i] = 0;
      m_prev[i] = 0; m_run[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_step(input logic [3:0] v);
    int ones, code;
    ones = $countones(v);
    for (int i = 0; i < 2; i++) begin
      m_inv[i] = 0;
      m_err[i] = 0;
      if (ones == 0) begin
        m_vld[i] = 0;
      end else if (ones > 1) begin
        m_vld[i] = 0;
        m_inv[i] = 1;
        m_have_ref[i] = 0;
        m_locked[i] = 0;
        m_run[i] = 0;
      end else begin
        code = $clog2(int'(v));
        m_vld[i] = 1;
        if (!m_have_ref[i]) begin
          m_have_ref[i] = 1;
          m_run[i] = 0;
        end else if (code == (m_prev[i] + 1) % 4) begin
          if (m_cnt[i] < m_cnt_max[i]) m_cnt[i]++;
          if (!m_locked[i]) begin
            m_run[i]++;
            if (m_run[i] == 4) m_locked[i] = 1;
          end
        end else if (code != m_prev[i]) begin
          m_err[i] = 1;
          m_locked[i] = 0;
          m_run[i] = 0;
        end
        m_prev[i] = code;
      end
    end
  endtask

  task automatic check_dut(input int i, input logic [1:0] eo, input logic v, input logic inv,
                           input logic err, input logic lk, input int cnt);
    n_vec++;
    if (eo !== 2'(m_prev[i]) || v !== m_vld[i] || inv !== m_inv[i] || err !== m_err[i] ||
        lk !== m_locked[i] || cnt != m_cnt[i]) begin
      n_bad++;
      $display("FAIL model cyc%0d dut%0d: got enc=%0d vld=%b inv=%b err=%b lk=%b cnt=%0d, want enc=%0d vld=%b inv=%b err=%b lk=%b cnt=%0d",
               cyc, i, eo, v, inv, err, lk, cnt,
               m_prev[i], m_vld[i], m_inv[i], m_err[i], m_locked[i], m_cnt[i]);
    end
  endtask

  task automatic compare_all();
    check_dut(0, eo_a, vld_a, inv_a, err_a, lk_a, int'(cnt_a));
    check_dut(1, eo_b, vld_b, inv_b, err_b, lk_b, int'(cnt_b));
  endtask

  task automatic lit(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic step(input logic [3:0] v);
    decoder_in = v;
    @(posedge clockpulse);
    cyc++;
    model_step(v);
    #2;
    compare_all();
  endtask

  // Pulls clear_ while the clock is high, checks the async effect, releases while low.
  task automatic async_clear();
    #1 clear_ = 1'b0;
    #1 model_reset();
    compare_all();
    lit("clear_locked", int'(lk_a), 0);
    #2 clear_ = 1'b1;
  endtask

  initial begin
    model_reset();
    #1 compare_all();
    lit("reset_cnt", int'(cnt_a), 0);
    #2 clear_ = 1'b1;

    // Clean up-count sequence: lock after the 5th sample.
    step(4'b0001); step(4'b0010); step(4'b0100);
    step(4'b1000);
    lit("wrap_enc3", int'(eo_a), 3);
    lit("not_yet_locked", int'(lk_a), 0);
    step(4'b0001);
    lit("lock_cnt", int'(cnt_a), 4);
    lit("lock_locked", int'(lk_a), 1);
    lit("lock_enc0", int'(eo_a), 0);

    // Locked at code 1, jump to 3.
    step(4'b0010);
    lit("sat_cnt", int'(cnt_b), 3);
    step(4'b1000);
    lit("jump_err", int'(err_a), 1);
    lit("jump_cnt", int'(cnt_a), 5);
    step(4'b0001);
    lit("after_jump_cnt", int'(cnt_a), 6);
    lit("after_jump_err", int'(err_a), 0);
    lit("after_jump_lk", int'(lk_a), 0);

    // Re-lock, then a multi-hot sample.
    step(4'b0010); step(4'b0100); step(4'b1000);
    lit("relock", int'(lk_a), 1);
    step(4'b0110);
    lit("multi_inv", int'(inv_a), 1);
    lit("multi_enc_hold", int'(eo_a), 3);
    step(4'b0100);
    lit("search_no_err", int'(err_a), 0);

    // Re-lock, then repeats and idle zeros must be neutral.
    step(4'b1000); step(4'b0001); step(4'b0010); step(4'b0100);
    for (int k = 0; k < 5; k++) step(4'b0100);
    for (int k = 0; k < 3; k++) step(4'b0000);
    lit("hold_locked", int'(lk_a), 1);
    lit("hold_cnt", int'(cnt_a), 13);

    // Clear while locked; lock must be earned again from SEARCH.
    async_clear();
    step(4'b0000);
    step(4'b1111);
    step(4'b0100);
    lit("post_clear_err", int'(err_a), 0);
    step(4'b1000); step(4'b0001); step(4'b0010);
    lit("post_clear_unlocked", int'(lk_a), 0);
    step(4'b0100);
    lit("post_clear_locked", int'(lk_a), 1);
    lit("post_clear_cnt", int'(cnt_a), 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
